// File: rtl/pe_pkg.sv
// pe_pkg: shared PE-group types and saturation helpers for the output drain.
package pe_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OUT_WIDTH  = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_e;
    function automatic longint sat_max(int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction
    function automatic longint sat_min(int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/pe_output_drain_if.sv
// pe_output_drain_if: config, PE input stream and FIFO readback signals of the drain.
interface pe_output_drain_if
    import pe_pkg::*;
#(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int OutWidth   = DEFAULT_OUT_WIDTH,
    parameter int FifoDepth  = 16,
    parameter int CountWidth = 16
);
    logic                         cfg_valid;
    logic                         cfg_rdy;
    logic [DataWidth-1:0]         cfg_bias;
    logic [4:0]                   cfg_shift;
    logic [CountWidth-1:0]        cfg_count;
    logic                         in_valid;
    logic                         in_rdy;
    logic [DataWidth-1:0]         in_data;
    logic                         out_valid;
    logic                         out_rdy;
    logic [OutWidth-1:0]          out_data;
    logic [$clog2(FifoDepth):0]   level;
    logic                         done;
    modport slave (
        input  cfg_valid, cfg_bias, cfg_shift, cfg_count, in_valid, in_data, out_rdy,
        output cfg_rdy, in_rdy, out_valid, out_data, level, done
    );
    modport master (
        output cfg_valid, cfg_bias, cfg_shift, cfg_count, in_valid, in_data, out_rdy,
        input  cfg_rdy, in_rdy, out_valid, out_data, level, done
    );
endinterface

// File: rtl/pe_sync_fifo.sv
// pe_sync_fifo: synchronous FIFO with occupancy output and global clock enable.
module pe_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);
    localparam int AW = $clog2(Depth);
    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic push, pop, full;
    assign full = level_q == (AW + 1)'(Depth);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign push = clk_en && push_i;
    assign pop = clk_en && pop_i && !empty_o;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
    // Upstream credit accounting must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/pe_output_drain.sv
// pe_output_drain: bias + round/shift + saturate PE sums into an output FIFO; counts results to done.
// Define PE_DRAIN_RELU_EN to clamp negative activations to zero.
module pe_output_drain
    import pe_pkg::*;
#(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int OutWidth   = DEFAULT_OUT_WIDTH,
    parameter int FifoDepth  = 16,
    parameter int CountWidth = 16
) (
    input logic clk,
    input logic rst,
    input logic clk_en,
    pe_output_drain_if.slave bus
);
    localparam int DW1 = DataWidth + 1;
    localparam int LW = $clog2(FifoDepth) + 1;
    localparam logic signed [DataWidth:0] SUM_MAX = DW1'(sat_max(DataWidth));
    localparam logic signed [DataWidth:0] SUM_MIN = DW1'(sat_min(DataWidth));
    localparam logic signed [DataWidth:0] OUT_MAX = DW1'(sat_max(OutWidth));
    localparam logic signed [DataWidth:0] OUT_MIN = DW1'(sat_min(OutWidth));
    drain_state_e state_q, state_d;
    logic signed [DataWidth-1:0] bias_q, bias_d, s1_q, s1_d;
    logic signed [OutWidth-1:0] s2_q, s2_d;
    logic signed [DataWidth:0] sum_w, rnd_w, shf_w, act_w;
    logic [4:0] shift_q, shift_d;
    logic [CountWidth-1:0] remaining_q, remaining_d;
    logic s1_vld_q, s2_vld_q;
    logic [1:0] inflight;
    logic cfg_fire, accept, pop, in_rdy, empty;
    logic [LW-1:0] level;
    logic [OutWidth-1:0] fifo_data;
    assign inflight = {1'b0, s1_vld_q} + {1'b0, s2_vld_q};
    assign cfg_fire = clk_en && bus.cfg_valid && state_q == IDLE;
    assign accept = clk_en && bus.in_valid && in_rdy;
    assign pop = clk_en && bus.out_rdy && !empty;
    always_comb begin
        in_rdy = state_q == RUN && remaining_q != '0 &&
                 (LW + 1)'(level) + (LW + 1)'(inflight) < (LW + 1)'(FifoDepth);
        state_d = state_q == IDLE ? (cfg_fire ? (bus.cfg_count == '0 ? DONE : RUN) : IDLE)
                : state_q == RUN  ? (remaining_q == '0 && inflight == 2'd0 ? DONE : RUN)
                : (level == '0 ? IDLE : DONE);
        bias_d = cfg_fire ? $signed(bus.cfg_bias) : bias_q;
        shift_d = cfg_fire ? bus.cfg_shift : shift_q;
        remaining_d = cfg_fire ? bus.cfg_count : accept ? remaining_q - 1'b1 : remaining_q;
        sum_w = DW1'($signed(bus.in_data)) + DW1'(bias_q);
        s1_d = sum_w > SUM_MAX ? DataWidth'(SUM_MAX) : sum_w < SUM_MIN ? DataWidth'(SUM_MIN) : DataWidth'(sum_w);
        // Round half up: add 2^(shift-1) before the arithmetic shift.
        rnd_w = DW1'(s1_q) + (shift_q != 5'd0 ? DW1'(1) << (shift_q - 5'd1) : DW1'(0));
        shf_w = rnd_w >>> shift_q;
`ifdef PE_DRAIN_RELU_EN
        act_w = shf_w[DataWidth] ? '0 : shf_w;
`else
        act_w = shf_w;
`endif
        s2_d = act_w > OUT_MAX ? OutWidth'(OUT_MAX) : act_w < OUT_MIN ? OutWidth'(OUT_MIN) : OutWidth'(act_w);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bias_q <= '0;
            shift_q <= '0;
            remaining_q <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            bias_q <= bias_d;
            shift_q <= shift_d;
            remaining_q <= remaining_d;
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
    pe_sync_fifo #(.Width(OutWidth), .Depth(FifoDepth)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .push_i(s2_vld_q),
        .push_data_i(s2_q),
        .pop_i(pop),
        .pop_data_o(fifo_data),
        .empty_o(empty),
        .level_o(level)
    );
    assign bus.cfg_rdy = state_q == IDLE;
    assign bus.in_rdy = in_rdy;
    assign bus.out_valid = !empty;
    assign bus.out_data = fifo_data;
    assign bus.level = level;
    assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_pe_output_drain.sv
// tb_pe_output_drain: directed vectors plus hand-written multi-cycle sequences for pe_output_drain.
module tb_pe_output_drain;
    logic clk, rst, clk_en;
    int checks = 0;
    int errors = 0;
    int got[32];
    pe_output_drain_if bus ();
    pe_output_drain dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus));

    typedef struct {
        int bias;
        int shift;
        int din;
        int exp;
        string name;
    } vec_t;
    vec_t vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    function automatic int relu(int v);
`ifdef PE_DRAIN_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic configure(input int b, input int s, input int c);
        bus.cfg_valid = 1'b1;
        bus.cfg_bias = b;
        bus.cfg_shift = 5'(s);
        bus.cfg_count = 16'(c);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send(input int d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        while (!bus.in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", n, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input int exp, input string name);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("recv_timeout", n, 0);
        check(name, int'($signed(bus.out_data)), exp);
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.cfg_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", n, 0);
    endtask

    task automatic drain(input int cnt, output int n);
        int k = 0;
        n = 0;
        bus.out_rdy = 1'b1;
        while (n < cnt && k < 200) begin
            if (bus.out_valid) begin
                got[n] = int'($signed(bus.out_data));
                n++;
            end
            @(negedge clk);
            k++;
        end
        bus.out_rdy = 1'b0;
    endtask

    initial begin
        int n, acc;
        vecs[0] = '{0, 0, 5, relu(5), "v_pass5"};
        vecs[1] = '{0, 0, -3, relu(-3), "v_neg3"};
        vecs[2] = '{0, 0, 200, relu(127), "v_sat_hi"};
        vecs[3] = '{10, 2, 5, relu(4), "v_bias_shift"};
        vecs[4] = '{0, 1, -7, relu(-3), "v_round_neg"};
        vecs[5] = '{1, 0, int'(32'h7FFF_FFFF), relu(127), "v_sum_sat_hi"};
        vecs[6] = '{-1, 0, int'(32'h8000_0000), relu(-128), "v_sum_sat_lo"};
        vecs[7] = '{0, 3, -20, relu(-2), "v_round_m20"};
        vecs[8] = '{0, 4, 24, relu(2), "v_round_24"};
        vecs[9] = '{0, 0, -200, relu(-128), "v_sat_lo"};
        rst = 1'b1;
        clk_en = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_bias = '0;
        bus.cfg_shift = '0;
        bus.cfg_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cfg_rdy", int'(bus.cfg_rdy), 1);
        check("rst_in_rdy", int'(bus.in_rdy), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_level", int'(bus.level), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            configure(vecs[i].bias, vecs[i].shift, 1);
            send(vecs[i].din);
            recv(vecs[i].exp, vecs[i].name);
            wait_idle();
        end

        // Three results held back, then drained; done stays up until FIFO observed empty.
        configure(0, 0, 3);
        send(5);
        send(-3);
        send(200);
        drain(3, n);
        check("seq_count", n, 3);
        check("seq_0", got[0], 5);
        check("seq_1", got[1], relu(-3));
        check("seq_2", got[2], 127);
        check("seq_done_after_pop", int'(bus.done), 1);
        check("seq_level", int'(bus.level), 0);
        @(negedge clk);
        check("seq_idle", int'(bus.cfg_rdy), 1);
        check("seq_done_clr", int'(bus.done), 0);

        // Backpressure: only FifoDepth results accepted while out_rdy=0.
        configure(0, 0, 20);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = acc + 1;
            if (bus.in_rdy) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("full_accepted", acc, 16);
        check("full_in_rdy", int'(bus.in_rdy), 0);
        check("full_level", int'(bus.level), 16);
        n = 0;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 200 && n < 20; k++) begin
            if (bus.out_valid) begin
                got[n] = int'($signed(bus.out_data));
                n++;
            end
            bus.in_valid = acc < 20;
            bus.in_data = acc + 1;
            if (acc < 20 && bus.in_rdy) acc++;
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        bus.in_valid = 1'b0;
        check("full_total_in", acc, 20);
        check("full_total_out", n, 20);
        for (int i = 0; i < 20; i++) check($sformatf("full_order_%0d", i), got[i], i + 1);
        wait_idle();

        // Zero-count layer: DONE for exactly one cycle.
        configure(0, 0, 0);
        check("zero_done", int'(bus.done), 1);
        check("zero_in_rdy", int'(bus.in_rdy), 0);
        check("zero_cfg_rdy", int'(bus.cfg_rdy), 0);
        @(negedge clk);
        check("zero_done_clr", int'(bus.done), 0);
        check("zero_idle", int'(bus.cfg_rdy), 1);

        // Stall: clk_en=0 freezes the FIFO even with out_rdy high.
        configure(0, 0, 2);
        send(9);
        send(-9);
        repeat (4) @(negedge clk);
        check("stall_pre_level", int'(bus.level), 2);
        check("stall_cfg_rdy", int'(bus.cfg_rdy), 0);
        clk_en = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_level", int'(bus.level), 2);
        check("stall_out_valid", int'(bus.out_valid), 1);
        bus.out_rdy = 1'b0;
        clk_en = 1'b1;
        recv(9, "stall_out0");
        recv(relu(-9), "stall_out1");
        wait_idle();

        // Reset mid-layer discards buffered data.
        configure(0, 0, 10);
        for (int i = 0; i < 5; i++) send(i + 1);
        repeat (3) @(negedge clk);
        check("mid_level", int'(bus.level), 5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_level", int'(bus.level), 0);
        check("mid_rst_cfg_rdy", int'(bus.cfg_rdy), 1);
        check("mid_rst_in_rdy", int'(bus.in_rdy), 0);
        rst = 1'b0;
        @(negedge clk);
        configure(0, 0, 1);
        send(42);
        recv(42, "post_rst_out");
        wait_idle();
        check("post_rst_idle", int'(bus.cfg_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
